lsu_mem_port: RTL



---
 rtl/lsu_mem_port_pkg.sv | 11 +
 rtl/lsu_mem_port_byte_lane.sv | 20 ++
 rtl/lsu_mem_port.sv | 88 ++++++++
 3 files changed

// File: rtl/lsu_mem_port_pkg.sv
// lsu_mem_port_pkg: access size and FSM state encodings shared by the load/store front-end
package lsu_mem_port_pkg;
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;
endpackage

// File: rtl/lsu_mem_port_byte_lane.sv
// lsu_byte_lane: big-endian load extract/extend and sub-word store merge on the addressed bytes
module lsu_byte_lane
  import lsu_mem_port_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_data
);
  logic sgn;
  always_comb begin
    sgn = ~uns & rdata[31];
    ld_data = size == SIZE_B ? {{24{sgn}}, rdata[31:24]} :
              size == SIZE_H ? {{16{sgn}}, rdata[31:16]} : rdata;
    st_data = size == SIZE_B ? {wdata[7:0], rdata[23:0]} :
              size == SIZE_H ? {wdata[15:0], rdata[15:0]} : wdata;
  end
endmodule

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: single-outstanding load/store front-end driving a 4-byte big-endian memory port
module lsu_mem_port
  import lsu_mem_port_pkg::*;
#(
  parameter int MEM_BYTES = 2048
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        mem_rdEna,
  output logic        mem_wrEna,
  output logic [31:0] mem_rdAddr,
  output logic [31:0] mem_wrAddr,
  output logic [31:0] mem_wrData,
  input  logic [31:0] mem_rdData
);
  logic [2:0]  state;
  logic        we, uns, err;
  logic [1:0]  size;
  logic [31:0] addr, wdata, res, ld_data, st_data;
  logic        word_st, bad;
  lsu_byte_lane u_lane (
    .size    (size),
    .uns     (uns),
    .rdata   (mem_rdData),
    .wdata   (wdata),
    .ld_data (ld_data),
    .st_data (st_data)
  );
  always_comb begin
    bad        = req_addr > 32'(MEM_BYTES - 4) || req_size == 2'b11;
    word_st    = we && size == SIZE_W;
    req_ready  = state == S_IDLE;
    rsp_valid  = state == S_RESP;
    rsp_data   = rsp_valid ? res : 32'd0;
    rsp_err    = rsp_valid & err;
    mem_rdEna  = state == S_ISSUE && !word_st;
    mem_wrEna  = (state == S_ISSUE && word_st) || state == S_WRITE;
    mem_rdAddr = mem_rdEna ? addr : 32'd0;
    mem_wrAddr = mem_wrEna ? addr : 32'd0;
    mem_wrData = mem_wrEna ? wdata : 32'd0;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= S_IDLE;
      we    <= 1'b0;
      uns   <= 1'b0;
      size  <= 2'b00;
      addr  <= 32'd0;
      wdata <= 32'd0;
      res   <= 32'd0;
      err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          we    <= req_we;
          uns   <= req_unsigned;
          size  <= req_size;
          addr  <= req_addr;
          wdata <= req_wdata;
          res   <= 32'd0;
          err   <= bad;
          state <= bad ? S_RESP : S_ISSUE;
        end
        S_ISSUE: state <= word_st ? S_RESP : S_DATA;
        S_DATA: begin
          // the store buffer is reused to hold the merged word for the write-back
          if (we) wdata <= st_data;
          else res <= ld_data;
          state <= we ? S_WRITE : S_RESP;
        end
        S_WRITE: state <= S_RESP;
        S_RESP: if (rsp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
